// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for one port of the RAM arbiter.
// The requester drives the request fields; the arbiter returns data and a ready pulse.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing the LC-3 RAM between the CPU
// and an I/O requester, with a wait-state timeout against a RAM that never answers.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      io,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_r,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              grant_io, last_io;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        cnt;
  logic              abort, dropped;
  logic [DATA_W-1:0] cpu_rdata_q, io_rdata_q;

  logic              take, pick_io, timeout_hit, finish, gnt_req, strobe;
  logic [DATA_W-1:0] cap;

  assign gnt_req     = grant_io ? io.req : cpu.req;
  assign timeout_hit = (state == WAIT) && !mem_r && (cnt == TO_LAST);
  assign finish      = (state == WAIT) && (mem_r || timeout_hit);
  assign cap         = (mem_r && !we_q) ? mem_rdata : '0;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    pick_io  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu.req || io.req) begin
          take     = 1'b1;
          // With both requesting, the port that did not win last time goes first.
          pick_io  = io.req && (!cpu.req || !last_io);
          state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = WAIT;
      WAIT:    if (finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_io    <= 1'b0;
      last_io     <= 1'b1;
      cnt         <= '0;
      abort       <= 1'b0;
      dropped     <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        grant_io <= pick_io;
        last_io  <= pick_io;
        abort    <= 1'b0;
        dropped  <= 1'b0;
      end
      if (state == ACCESS)
        cnt <= '0;
      else if (state == WAIT && !mem_r && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      // A requester that lets go mid-access forfeits its completion.
      if ((state == ACCESS || state == WAIT) && !gnt_req)
        dropped <= 1'b1;
      if (finish) begin
        abort <= timeout_hit;
        if (gnt_req && !dropped) begin
          if (grant_io) io_rdata_q  <= cap;
          else          cpu_rdata_q <= cap;
        end
      end
    end
  end

  // Transaction latches: captured once at grant, ignored afterwards.
  always_ff @(posedge clock) begin
    if (take) begin
      we_q    <= pick_io ? io.we    : cpu.we;
      addr_q  <= pick_io ? io.addr  : cpu.addr;
      wdata_q <= pick_io ? io.wdata : cpu.wdata;
    end
  end

  assign strobe    = (state == ACCESS) || (state == WAIT);
  assign mem_read  = strobe && !we_q;
  assign mem_write = strobe && we_q;
  assign mem_addr  = strobe ? addr_q  : '0;
  assign mem_wdata = strobe ? wdata_q : '0;
  assign busy      = (state != IDLE);
  assign err       = (state == DONE) && abort;

  assign cpu.ready = (state == DONE) && !dropped && !grant_io;
  assign io.ready  = (state == DONE) && !dropped && grant_io;
  assign cpu.rdata = cpu_rdata_q;
  assign io.rdata  = io_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a scripted RAM responder,
// and a monitor that checks every ready pulse against the queued expectation.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read, mem_write, mem_r, busy, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter_if cpu_if ();
  mem_arbiter_if io_if ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .cpu(cpu_if), .io(io_if),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_r(mem_r),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          io;
    logic [15:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  int mon_errs = 0, mon_checks = 0;

  // RAM responder: returns addr ^ 16'h2234 and raises mem_r in strobe cycle rsp_at.
  int          rsp_at = 0;
  int          stb_cnt = 0;
  int          last_len = 0;
  bit          chk_bus = 1'b0;
  bit          bus_bad = 1'b0;
  bit          overlap_seen = 1'b0;
  logic [15:0] exp_addr = '0, exp_wdata = '0;

  initial begin
    mem_r = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap_seen = 1'b1;
    if (mem_read || mem_write) begin
      if (stb_cnt == 0) bus_bad = 1'b0;
      stb_cnt = stb_cnt + 1;
      if (chk_bus && (mem_addr != exp_addr || (mem_write && mem_wdata != exp_wdata)))
        bus_bad = 1'b1;
    end else begin
      if (stb_cnt != 0) last_len = stb_cnt;
      stb_cnt = 0;
    end
    mem_r     = (rsp_at != 0) && (stb_cnt == rsp_at);
    mem_rdata = mem_addr ^ 16'h2234;
  end

  // Monitor: pops one expectation per ready pulse.
  bit   prev_cpu = 1'b0, prev_io = 1'b0;
  exp_t e;
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_if.ready || io_if.ready) begin
        mon_checks++;
        if (cpu_if.ready && io_if.ready) begin
          mon_errs++;
          $display("FAIL both_ready: cpu_ready=1 io_ready=1, required one at most");
        end else if (sb.size() == 0) begin
          mon_errs++;
          $display("FAIL unexpected_ready: cpu_ready=%0b io_ready=%0b with nothing expected",
                   cpu_if.ready, io_if.ready);
        end else begin
          e = sb.pop_front();
          if (io_if.ready != e.io || err != e.err ||
              (e.io ? io_if.rdata : cpu_if.rdata) != e.rdata) begin
            mon_errs++;
            $display("FAIL completion: port_io=%0b rdata=%h err=%0b, required port_io=%0b rdata=%h err=%0b",
                     io_if.ready, e.io ? io_if.rdata : cpu_if.rdata, err, e.io, e.rdata, e.err);
          end
        end
        mon_checks++;
        if ((cpu_if.ready && prev_cpu) || (io_if.ready && prev_io)) begin
          mon_errs++;
          $display("FAIL ready_width: ready high two cycles running, required single-cycle pulse");
        end
      end else if (err) begin
        mon_checks++;
        mon_errs++;
        $display("FAIL err_alone: err=1 without a ready pulse");
      end
      prev_cpu = cpu_if.ready;
      prev_io  = io_if.ready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_ready(input bit port_io, input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clock);
      if (port_io ? io_if.ready : cpu_if.ready) begin
        lat = n;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout: no ready on port_io=%0b within %0d cycles", port_io, limit);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_read"},  {31'd0, mem_read},  32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_err"},       {31'd0, err},       32'd0);
    chk({tag, "_ready"},     {30'd0, cpu_if.ready, io_if.ready}, 32'd0);
    chk({tag, "_rdata"},     {cpu_if.rdata, io_if.rdata}, 32'd0);
  endtask

  int lat;
  int io_pulses;

  initial begin
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    io_if.req  = 0; io_if.we  = 0; io_if.addr  = '0; io_if.wdata  = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single CPU read, mem_r two cycles after mem_read rises.
    @(negedge clock);
    chk_bus = 1; exp_addr = 16'h3000; rsp_at = 3;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 16'h3000;
    sb.push_back('{io: 1'b0, rdata: 16'h1234, err: 1'b0});
    wait_ready(1'b0, 20, lat);
    cpu_if.req = 0;
    chk("cpu_read_latency", lat, 4);
    @(negedge clock);
    chk("cpu_read_strobe_len", last_len, 3);
    chk("cpu_read_bus", {31'd0, bus_bad}, 32'd0);

    // I/O write, mem_r in the first WAIT cycle.
    exp_addr = 16'hFE06; exp_wdata = 16'h0041; rsp_at = 2;
    io_if.req = 1; io_if.we = 1; io_if.addr = 16'hFE06; io_if.wdata = 16'h0041;
    sb.push_back('{io: 1'b1, rdata: 16'h0000, err: 1'b0});
    wait_ready(1'b1, 20, lat);
    io_if.req = 0;
    chk("io_write_latency", lat, 3);
    @(negedge clock);
    chk("io_write_strobe_len", last_len, 2);
    chk("io_write_bus", {31'd0, bus_bad}, 32'd0);

    // Address changes after grant; the latched 3000 must stay on the bus.
    exp_addr = 16'h3000; rsp_at = 3;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 16'h3000;
    sb.push_back('{io: 1'b0, rdata: 16'h1234, err: 1'b0});
    @(negedge clock);
    cpu_if.addr = 16'h4000;
    wait_ready(1'b0, 20, lat);
    cpu_if.req = 0;
    @(negedge clock);
    chk("addr_hold_bus", {31'd0, bus_bad}, 32'd0);

    // Timeout: RAM never answers.
    exp_addr = 16'h0123; rsp_at = 0;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 16'h0123;
    sb.push_back('{io: 1'b0, rdata: 16'h0000, err: 1'b1});
    wait_ready(1'b0, 40, lat);
    cpu_if.req = 0;
    chk("timeout_latency", lat, 17);
    chk("timeout_strobe_dropped", {31'd0, mem_read}, 32'd0);
    chk("timeout_busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("timeout_busy_falls", {31'd0, busy}, 32'd0);
    chk("timeout_strobe_len", last_len, 16);

    // Simultaneous requests after reset: CPU, IO, CPU, IO.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_bus = 0; rsp_at = 2;
    cpu_if.we = 0; cpu_if.addr = 16'h1000;
    io_if.we  = 0; io_if.addr  = 16'h2000;
    sb.push_back('{io: 1'b0, rdata: 16'h3234, err: 1'b0});
    sb.push_back('{io: 1'b1, rdata: 16'h0234, err: 1'b0});
    sb.push_back('{io: 1'b0, rdata: 16'h3234, err: 1'b0});
    sb.push_back('{io: 1'b1, rdata: 16'h0234, err: 1'b0});
    cpu_if.req = 1; io_if.req = 1;
    wait_ready(1'b0, 20, lat);
    wait_ready(1'b1, 20, lat);
    wait_ready(1'b0, 20, lat);
    wait_ready(1'b1, 20, lat);
    cpu_if.req = 0; io_if.req = 0;
    @(negedge clock);
    chk("rr_queue_drained", sb.size(), 0);

    // Reset during WAIT: everything drops at once, no completion.
    rsp_at = 0;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 16'h3000;
    repeat (2) @(negedge clock);
    chk("abort_in_wait", {30'd0, busy, mem_read}, 32'd3);
    reset = 1'b1; cpu_if.req = 0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Establish a known io_rdata, then drop io_req during WAIT.
    rsp_at = 2;
    io_if.req = 1; io_if.we = 0; io_if.addr = 16'h2000;
    sb.push_back('{io: 1'b1, rdata: 16'h0234, err: 1'b0});
    wait_ready(1'b1, 20, lat);
    io_if.req = 0;
    @(negedge clock);
    rsp_at = 3;
    io_if.req = 1; io_if.addr = 16'h3000;
    repeat (2) @(negedge clock);
    io_if.req = 0;
    io_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (io_if.ready) io_pulses++;
    end
    chk("drop_no_ready", io_pulses, 0);
    chk("drop_rdata_kept", {16'd0, io_if.rdata}, 32'h0234);
    chk("drop_ram_finished", last_len, 3);
    chk("drop_back_idle", {31'd0, busy}, 32'd0);

    chk("strobes_exclusive", {31'd0, overlap_seen}, 32'd0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors + mon_errs, checks + mon_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and access sequencer for the single LC-3 RAM.
- Shares the RAM between the CPU (FSM-driven MAR/MDR accesses) and an I/O requester (console/display DMA).
- Latches the winning request, drives the RAM read/write strobes, waits for the RAM ready flag R, and returns data with a one-cycle ready pulse.
- Adds timeout protection against a RAM that never asserts R.

Parameters:
- ADDR_W, 16, address width (MAR width)
- DATA_W, 16, data width (MDR width)
- TIMEOUT, 15, max cycles in WAIT before abort; legal range 1..255

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request, level, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid when cpu_ready = 1
- cpu_ready  out  1  one-cycle completion pulse
- io_req, io_we, io_addr, io_wdata, io_rdata, io_ready  same as cpu_* for the I/O port
- mem_read  out  1  RAM read strobe
- mem_write  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- mem_r  in  1  RAM ready (R), samples mem_rdata
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, immediate), all outputs 0:
  - State is IDLE; timeout counter is 0.
  - last_grant = IO, so the CPU wins the first tie.
- States are IDLE, ACCESS, WAIT and DONE.
- IDLE:
  - If any req is high, grant one requester and go to ACCESS.
  - Tie rule is round-robin: grant the port not in last_grant, then update last_grant.
  - A single requester wins regardless of last_grant.
  - On grant, latch we, addr and wdata of the winner. Later changes to those inputs are ignored for that transaction.
- ACCESS (1 cycle):
  - Drive mem_addr and mem_wdata from the latches; assert mem_read = !we or mem_write = we.
  - Go to WAIT; clear the counter.
- WAIT:
  - Hold the strobe and address.
  - If mem_r = 1: capture mem_rdata (reads only), drop strobes, go to DONE.
  - Otherwise increment the counter. When counter = TIMEOUT: drop strobes, pulse err, go to DONE with abort flag set.
- DONE (1 cycle):
  - Pulse ready on the granted port only.
  - rdata holds the captured data on a successful read, 16'h0000 on abort or on a write.
  - rdata holds its value until the next completion on that port.
  - Go to IDLE. No back-to-back grant in the same cycle, so a new grant occurs in the following IDLE cycle.
- Minimum latency: req high at cycle 0 (IDLE) and mem_r high in the first WAIT cycle gives ready at cycle 3.
- mem_read and mem_write are never high together. The strobes are zero in IDLE and DONE.
- Requester drops req mid-transaction: the transaction completes on the RAM, but no ready pulse is issued and rdata is unchanged.
- mem_r high outside WAIT is ignored.
- reset mid-transaction: strobes drop immediately. No ready and no err are issued.
- Counter is 8 bits and saturates; there is no wrap.

Test Plan:
- Single CPU read:
  - Stimulus: cpu_req = 1, cpu_we = 0, cpu_addr = 16'h3000; RAM asserts mem_r 2 cycles after mem_read with mem_rdata = 16'h1234.
  - Required: mem_addr = 16'h3000, mem_read high 3 cycles, then cpu_ready pulses once with cpu_rdata = 16'h1234; io_ready stays 0.
- I/O write:
  - Stimulus: io_req = 1, io_we = 1, io_addr = 16'hFE06, io_wdata = 16'h0041; mem_r = 1 in the first WAIT cycle.
  - Required: mem_write high 2 cycles with mem_wdata = 16'h0041; io_ready pulse at cycle 3; io_rdata = 16'h0000.
- Simultaneous requests after reset:
  - Stimulus: cpu_req and io_req both held high.
  - Required: grants alternate CPU, IO, CPU, IO; each ready pulse is exactly one cycle.
- Timeout, TIMEOUT = 15:
  - Stimulus: cpu_req read with mem_r held 0.
  - Required: after 15 WAIT cycles, strobes drop, err and cpu_ready pulse together, cpu_rdata = 16'h0000, busy falls in the next cycle.
- Input change after grant:
  - Stimulus: change cpu_addr to 16'h4000 one cycle after grant.
  - Required: mem_addr stays at the latched 16'h3000 for the whole transaction.
- Abort paths:
  - Stimulus: assert reset during WAIT, then separately drop io_req during WAIT.
  - Required, reset: all outputs 0 within the same cycle, no ready.
  - Required, dropped req: the access finishes on the RAM, io_ready is never pulsed, and io_rdata keeps its previous value.
